// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: assembles one 32-bit little-endian word from a
// byte-wide synchronous memory, sharing the memory port with a program loader.
module imem_fetch_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_busy,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_code,
    output logic              instr_fault,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [32:0] LAST_BYTE = 33'((64'd1 << ADDR_W) - 64'd1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        idx_q, idx_d;
    logic              rd_vld_q, rd_vld_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic [31:0]       code_q, code_d;
    logic              fault_q, fault_d;
    logic              pc_bad;

    // Range test is done in 33 bits so a pc near 2**32 cannot wrap into range.
    assign pc_bad = (fetch_pc[1:0] != 2'b00) || (({1'b0, fetch_pc} + 33'd3) > LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            code_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            code_q   <= code_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idx_d     = idx_q;
        rd_vld_d  = 1'b0;
        rd_idx_d  = rd_idx_q;
        code_d    = code_q;
        fault_d   = fault_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;

        // Read data returns one cycle after its address; land it in its byte lane.
        if (rd_vld_q) begin
            code_d[8*rd_idx_q +: 8] = mem_rdata;
        end

        if (ld_we) begin
            mem_addr  = ld_addr;
            mem_we    = 1'b1;
            mem_wdata = ld_data;
        end

        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    pc_d   = fetch_pc[ADDR_W-1:0];
                    idx_d  = '0;
                    code_d = '0;
                    if (pc_bad) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!ld_we) begin
                    mem_addr = pc_q + ADDR_W'(idx_q);
                    rd_vld_d = 1'b1;
                    rd_idx_d = idx_q;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (instr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fetch_busy  = (state_q != IDLE);
    assign instr_valid = (state_q == DONE);
    assign instr_code  = code_q;
    assign instr_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: behavioural byte memory plus a
// cycle-walk reference model of issue order, loader priority and latency.
module tb_imem_fetch_ctrl;

    localparam int ADDR_W = 11;
    localparam int MSIZE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_busy;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_code;
    logic              instr_fault;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    imem_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_busy(fetch_busy),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_code(instr_code), .instr_fault(instr_fault),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT: synchronous write, registered read.
    logic [7:0] mem [MSIZE];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
    end

    // Reference copy of memory contents, advanced by the model in cycle order.
    logic [7:0]        shadow [MSIZE];
    logic [ADDR_W-1:0] ld_a [32];
    logic [7:0]        ld_d [32];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] pc);
        longint unsigned top;
        top = longint'(pc) + 3;
        return (pc[1:0] != 2'b00) || (top > longint'(MSIZE - 1));
    endfunction

    // One complete fetch. mask bit c = loader write during cycle c after acceptance.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] mask, input int hold);
        logic [7:0]  expb [4];
        logic [31:0] exp_code;
        int          k, lat;
        logic        flt;
        flt = is_fault(pc);
        lat = 1;
        k   = 0;
        if (!flt) begin
            lat = 1000;
            for (int c = 0; c < 32; c++) begin
                if (c >= lat) break;
                if (mask[c]) shadow[ld_a[c]] = ld_d[c];
                else if (k < 4) begin
                    expb[k] = shadow[pc[ADDR_W-1:0] + ADDR_W'(k)];
                    k++;
                    if (k == 4) lat = c + 2;
                end
            end
        end
        exp_code = flt ? 32'h0 : {expb[3], expb[2], expb[1], expb[0]};

        @(negedge clk);
        chk("idle_busy", {31'b0, fetch_busy}, 32'h0);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(negedge clk);
        if (flt) begin
            fetch_req = 1'b0;
            chk("fault_valid", {31'b0, instr_valid}, 32'h1);
            chk("fault_flag", {31'b0, instr_fault}, 32'h1);
            chk("fault_code", instr_code, 32'h0);
            chk("fault_no_read", {20'b0, mem_we, mem_addr}, 32'h0);
        end else begin
            for (int c = 0; c <= lat; c++) begin
                if (c < lat) begin
                    chk("lat_not_valid", {31'b0, instr_valid}, 32'h0);
                    chk("busy", {31'b0, fetch_busy}, 32'h1);
                    ld_we     = mask[c];
                    ld_addr   = ld_a[c];
                    ld_data   = ld_d[c];
                    fetch_req = 1'($urandom_range(0, 1));
                    fetch_pc  = $urandom;
                    @(negedge clk);
                end else begin
                    ld_we     = 1'b0;
                    fetch_req = 1'b0;
                    chk("lat_valid", {31'b0, instr_valid}, 32'h1);
                    chk("code", instr_code, exp_code);
                    chk("no_fault", {31'b0, instr_fault}, 32'h0);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            instr_ready = 1'b0;
            fetch_req   = 1'b1;
            fetch_pc    = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_code", instr_code, exp_code);
            chk("hold_fault", {31'b0, instr_fault}, {31'b0, flt});
        end
        instr_ready = 1'b1;
        fetch_req   = 1'b1;
        fetch_pc    = 32'h0000_0010;
        @(negedge clk);
        instr_ready = 1'b0;
        fetch_req   = 1'b0;
        chk("post_hs_valid", {31'b0, instr_valid}, 32'h0);
        chk("post_hs_busy", {31'b0, fetch_busy}, 32'h0);
        chk("idle_mem", {20'b0, mem_we, mem_addr}, 32'h0);
    endtask

    initial begin
        logic [31:0] pc, mask;
        int          r;
        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; instr_ready = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < MSIZE; i++) shadow[i] = 8'($urandom);
        shadow[16'h10] = 8'h93; shadow[16'h11] = 8'h00;
        shadow[16'h12] = 8'h50; shadow[16'h13] = 8'h00;
        for (int i = 0; i < 32; i++) begin ld_a[i] = '0; ld_d[i] = '0; end
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_busy", {31'b0, fetch_busy}, 32'h0);
        chk("rst_code", instr_code, 32'h0);
        chk("rst_fault", {31'b0, instr_fault}, 32'h0);

        // Whole image goes in through the loader path while held in reset.
        for (int i = 0; i < MSIZE; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = ADDR_W'(i); ld_data = shadow[i];
            if (i < 3) begin
                #1;
                chk("rst_ld_port", {19'b0, mem_we, mem_wdata, 1'b0, mem_addr},
                    {19'b0, 1'b1, shadow[i], 1'b0, ADDR_W'(i)});
            end
        end
        @(negedge clk);
        ld_we = 1'b0;
        rst   = 1'b0;

        // Baseline fetch at 0x10 and a 3-cycle stall in DONE.
        run_fetch(32'h10, 32'h0, 3);

        // Two loader cycles during ISSUE to unrelated bytes.
        ld_a[1] = 11'h300; ld_d[1] = 8'h5A;
        ld_a[2] = 11'h301; ld_d[2] = 8'hC3;
        run_fetch(32'h10, 32'h6, 0);
        chk("ld_byte0", {24'b0, mem[11'h300]}, 32'h5A);
        chk("ld_byte1", {24'b0, mem[11'h301]}, 32'hC3);

        // Boundary and alignment faults.
        run_fetch(32'h12, 32'h0, 1);
        run_fetch(32'h7FD, 32'h0, 0);
        run_fetch(32'h7FC, 32'h0, 0);
        run_fetch(32'hFFFF_FFFC, 32'h0, 0);

        // Same-address loader write before byte 3 issues, then after it.
        shadow[11'h13] = 8'h00;
        ld_a[1] = 11'h13; ld_d[1] = 8'hAA;
        run_fetch(32'h10, 32'h2, 0);
        ld_a[4] = 11'h13; ld_d[4] = 8'h77;
        run_fetch(32'h10, 32'h10, 0);
        run_fetch(32'h10, 32'h0, 0);

        // Asynchronous reset part-way through ISSUE.
        @(negedge clk);
        fetch_req = 1'b1; fetch_pc = 32'h10;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_issue_code", instr_code, {24'b0, shadow[11'h10]});
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, fetch_busy}, 32'h0);
        chk("async_rst_code", instr_code, 32'h0);
        chk("async_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_rst_fault", {31'b0, instr_fault}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_fetch(32'h10, 32'h0, 0);

        // Randomized fetches with random loader traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       pc = {21'b0, 9'($urandom_range(0, 511)), 2'b00};
            else if (r == 6) pc = {21'b0, 9'($urandom_range(0, 511)), 2'($urandom_range(1, 3))};
            else if (r == 7) pc = 32'h7FD + 32'($urandom_range(0, 8));
            else if (r == 8) pc = 32'h7FC;
            else             pc = $urandom | 32'h0001_0000;
            mask = $urandom & $urandom & $urandom & 32'h0000_FFFF;
            for (int i = 0; i < 32; i++) begin
                ld_a[i] = ($urandom_range(0, 1) == 1) ? pc[ADDR_W-1:0] + ADDR_W'($urandom_range(0, 3))
                                                      : ADDR_W'($urandom);
                ld_d[i] = 8'($urandom);
            end
            run_fetch(pc, mask, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the byte-address width of the instruction memory (2**ADDR_W bytes).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port fetch_req, input, 1, core requests one instruction fetch.
REQ-005 SHALL have port fetch_pc, input, 32, byte address of the instruction, sampled on acceptance.
REQ-006 SHALL have port fetch_busy, output, 1, high whenever state is not IDLE.
REQ-007 SHALL have port instr_valid, output, 1, instruction word available.
REQ-008 SHALL have port instr_ready, input, 1, core consumes the instruction word.
REQ-009 SHALL have port instr_code, output, 32, assembled instruction word.
REQ-010 SHALL have port instr_fault, output, 1, fetch_pc misaligned or out of range.
REQ-011 SHALL have port ld_we, input, 1, program loader byte-write strobe.
REQ-012 SHALL have port ld_addr, input, ADDR_W, loader byte address.
REQ-013 SHALL have port ld_data, input, 8, loader write byte.
REQ-014 SHALL have port mem_addr, output, ADDR_W, byte address to the memory.
REQ-015 SHALL have port mem_we, output, 1, memory write enable.
REQ-016 SHALL have port mem_wdata, output, 8, memory write byte.
REQ-017 SHALL have port mem_rdata, input, 8, memory read byte, valid one cycle after a read address is driven with mem_we=0.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-019 SHALL accept a request only when state=IDLE and fetch_req=1; fetch_pc is captured on that edge.
REQ-020 SHALL, on acceptance with fetch_pc[1:0]!=0 or fetch_pc+3 > 2**ADDR_W-1 (computed in 33 bits, no wrap), go directly to DONE with instr_fault=1 and instr_code=0, issuing no reads.
REQ-021 SHALL, on a valid acceptance, go to ISSUE with byte index 0.
REQ-022 SHALL, in ISSUE with ld_we=0, drive mem_addr=pc+idx, mem_we=0, then increment idx; after idx 3 is issued, go to DRAIN.
REQ-023 SHALL give the loader absolute priority: any cycle with ld_we=1 drives mem_addr=ld_addr, mem_we=1, mem_wdata=ld_data, and ISSUE holds idx for that cycle.
REQ-024 SHALL capture mem_rdata on the edge after each issued read into byte idx of instr_code (little-endian: byte 0 -> bits 7:0, byte 3 -> bits 31:24).
REQ-025 SHALL in DRAIN capture byte 3 and go to DONE; a loader write during DRAIN does not affect the capture.
REQ-026 SHALL in DONE hold instr_valid=1 and instr_code/instr_fault stable until instr_ready=1, then return to IDLE with instr_valid=0 on that edge.
REQ-027 SHALL yield fetch latency of 5 edges from accepting edge to instr_valid=1 with no loader writes, plus one edge per ld_we cycle during ISSUE.
REQ-028 SHALL ignore fetch_req and fetch_pc changes outside IDLE; back-to-back fetch is accepted no earlier than the edge after instr_ready handshake.
REQ-029 SHALL, when no loader write and no issue occurs, drive mem_we=0 and mem_addr=0.
REQ-030 SHALL return the byte value present at its issue cycle; a loader write to the same address in an earlier cycle is visible, in a later cycle is not.

Reset
REQ-031 SHALL on rst=1 immediately force state=IDLE, idx=0, instr_valid=0, instr_code=0, instr_fault=0, fetch_busy=0, discarding any in-flight fetch.
REQ-032 SHALL while rst=1 still pass loader writes combinationally to mem_addr/mem_we/mem_wdata.

Verification
REQ-033 SHALL cover: memory bytes 0x10..0x13 = 93,00,50,00, fetch_pc=0x10, no loader -> instr_valid 5 edges after acceptance, instr_code=0x00500093, instr_fault=0.
REQ-034 SHALL cover: same fetch with ld_we=1 for 2 cycles during ISSUE -> instr_valid after 7 edges, same instr_code, loader bytes written.
REQ-035 SHALL cover: fetch_pc=0x12 -> DONE next edge, instr_fault=1, instr_code=0, no mem read issued; fetch_pc=0x7FD (ADDR_W=11) -> fault; fetch_pc=0x7FC -> no fault.
REQ-036 SHALL cover: instr_ready held 0 for 3 cycles in DONE -> instr_valid and instr_code stable; fetch_req=1 with new pc ignored until after handshake.
REQ-037 SHALL cover: rst asserted mid-ISSUE (idx=2) -> outputs zero asynchronously, state IDLE; next fetch returns correct word.
REQ-038 SHALL cover: loader writes 0xAA to pc+3 before byte 3 issue -> instr_code[31:24]=0xAA; write after issue -> old byte returned.
